// File: rtl/calc_opstack_if.sv
// Operand-stack bus: push sources and stack commands in, ALU operands and status out.
interface calc_opstack_if #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int NSRC  = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [NSRC*W-1:0] din;
   logic [NSRC-1:0]   ld;
   logic              pop;
   logic              swap;
   logic              dup;
   logic              clr_err;
   logic [W-1:0]      top;
   logic [W-1:0]      next;
   logic [CW-1:0]     count;
   logic              empty;
   logic              full;
   logic              err;

   modport master (
      output din, ld, pop, swap, dup, clr_err,
      input  top, next, count, empty, full, err
   );

   modport slave (
      input  din, ld, pop, swap, dup, clr_err,
      output top, next, count, empty, full, err
   );
endinterface

// File: rtl/calc_opstack.sv
// Operand stack feeding the ALU: prioritised multi-source push plus pop/swap/dup,
// occupancy count and a sticky illegal-operation flag. One operation per cycle.
module calc_opstack #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int NSRC  = 2
) (
   input  logic          clk,
   input  logic          rst,
   calc_opstack_if.slave bus
);
   localparam int            CW       = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_TWO  = CW'(2);

   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUSH,
      OP_DUP,
      OP_SWAP,
      OP_POP
   } op_e;

   logic [W-1:0]  stk_p0 [DEPTH];
   logic [CW-1:0] cnt_p0;
   logic          err_p0;

   logic [W-1:0]  stk_nxt [DEPTH];
   logic [CW-1:0] cnt_nxt;
   logic          err_nxt;
   op_e           op;
   logic          illegal;
   logic [W-1:0]  push_val;

   // Highest set ld bit wins, so later iterations overwrite earlier ones.
   function automatic logic [W-1:0] sel_src(input logic [NSRC*W-1:0] d,
                                            input logic [NSRC-1:0]   l);
      logic [W-1:0] v;
      v = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (l[k]) v = d[k*W +: W];
      end
      return v;
   endfunction

   function automatic op_e decode_op(input logic [NSRC-1:0] l, input logic d,
                                     input logic s, input logic p);
      if (|l)    return OP_PUSH;
      else if (d) return OP_DUP;
      else if (s) return OP_SWAP;
      else if (p) return OP_POP;
      else        return OP_NONE;
   endfunction

   function automatic logic is_illegal(input op_e o, input logic [CW-1:0] c);
      case (o)
         OP_PUSH: return (c == CNT_FULL);
         OP_DUP:  return (c == CNT_FULL) || (c == '0);
         OP_SWAP: return (c < CNT_TWO);
         OP_POP:  return (c == '0);
         default: return 1'b0;
      endcase
   endfunction

   assign op       = decode_op(bus.ld, bus.dup, bus.swap, bus.pop);
   assign illegal  = is_illegal(op, cnt_p0);
   assign push_val = (op == OP_DUP) ? stk_p0[0] : sel_src(bus.din, bus.ld);

   // Entries beyond count are kept at zero, so shifts never need masking:
   // a legal push drops the already-zero last entry, a pop shifts zero in.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) stk_nxt[i] = stk_p0[i];
      cnt_nxt = cnt_p0;
      if (!illegal) begin
         case (op)
            OP_PUSH, OP_DUP: begin
               for (int i = DEPTH - 1; i > 0; i--) stk_nxt[i] = stk_p0[i-1];
               stk_nxt[0] = push_val;
               cnt_nxt    = cnt_p0 + CNT_ONE;
            end
            OP_SWAP: begin
               stk_nxt[0] = stk_p0[1];
               stk_nxt[1] = stk_p0[0];
            end
            OP_POP: begin
               for (int i = 0; i < DEPTH - 1; i++) stk_nxt[i] = stk_p0[i+1];
               stk_nxt[DEPTH-1] = '0;
               cnt_nxt          = cnt_p0 - CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   // Setting the flag takes precedence over clearing it in the same cycle.
   always_comb begin
      err_nxt = err_p0;
      if (bus.clr_err) err_nxt = 1'b0;
      if (illegal)     err_nxt = 1'b1;
   end

   // Stage 0: architectural stack state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stk_p0[i] <= '0;
         cnt_p0 <= '0;
         err_p0 <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) stk_p0[i] <= stk_nxt[i];
         cnt_p0 <= cnt_nxt;
         err_p0 <= err_nxt;
      end
   end

   assign bus.top   = stk_p0[0];
   assign bus.next  = stk_p0[1];
   assign bus.count = cnt_p0;
   assign bus.empty = (cnt_p0 == '0);
   assign bus.full  = (cnt_p0 == CNT_FULL);
   assign bus.err   = err_p0;
endmodule

// File: doc/calc_opstack.md
# calc_opstack

Parametrised operand stack for the calculator datapath: a generalised multi-source load register that holds up to DEPTH operands of width W. Each push selects one of NSRC input sources by fixed priority. The stack also supports pop, swap and dup, and reports occupancy and a sticky error flag. It sits between the operand sources (keypad entry, ALU result, constants) and the ALU, whose A/B inputs are driven from `top`/`next`.

## Interface
- `W`, default 8: operand width in bits.
- `DEPTH`, default 4: stack entries; DEPTH ≥ 2.
- `NSRC`, default 2: number of load sources; NSRC ≥ 1.
- `CW`, derived, = $clog2(DEPTH+1): width of the occupancy count.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  NSRC*W  packed sources; source k occupies bits [k*W +: W].
- `ld`  in  NSRC  push request per source; the highest set index wins.
- `pop`  in  1  discard the top entry.
- `swap`  in  1  exchange the top and next entries.
- `dup`  in  1  push a copy of the top entry.
- `clr_err`  in  1  clear the sticky error flag.
- `top`  out  W  entry 0, or 0 when empty.
- `next`  out  W  entry 1, or 0 when count < 2.
- `count`  out  CW  number of valid entries, 0..DEPTH.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `err`  out  1  sticky illegal-operation flag.

## Operation
- One operation per cycle. Priority: `rst` > any `ld` > `dup` > `swap` > `pop`. Lower-priority requests in the same cycle are ignored silently and do not set `err`.
- **Push** (`ld` != 0): select source k = highest set bit of `ld`, so source 1 beats source 0. Entries shift down one place, entry 0 ← din[k], count+1.
- **Dup**: entries shift down one place, entry 0 keeps its value, count+1.
- **Swap**: entry 0 ↔ entry 1; count is unchanged.
- **Pop**: entries shift up one place, count−1. Vacated entries are zeroed.
- **Illegal operations**:
  - push or dup when full;
  - dup when empty;
  - swap when count < 2;
  - pop when empty.
- **Effect of an illegal operation**: stack contents and count are unchanged, and `err` ← 1.
- **Error flag**:
  - `err` stays set until `clr_err` or `rst`.
  - If `clr_err` and an illegal operation occur in the same cycle, `err` ends at 1 (set wins).
  - `clr_err` has no effect on the stack.
- **Invalid entries**: entries at index ≥ count always hold 0, so `top` and `next` read 0 when invalid.
- **Reset values**: all entries 0, `count`=0, `empty`=1, `full`=0, `err`=0, `top`=0, `next`=0.

## Timing
- All outputs come from registers or are decoded from registered state; no combinational path from inputs to outputs.
- Latency is 1 cycle: an operation sampled at edge t is visible on `top`/`next`/`count`/flags after edge t.
- Back-to-back operations are allowed every cycle. Push at full followed by pop in the next cycle works normally.
- `rst` asserted mid-sequence overrides all requests in that cycle. The state after that edge is the reset state.
- `ld` bits are level-sampled per cycle. Holding `ld` high for n cycles gives n pushes until full, then `err`.

## Test plan
- **Reset and first push**: rst for 1 cycle, then ld=2'b01, din={8'h00,8'h12} -> top=0x12, next=0, count=1, empty=0, err=0.
- **Source priority**: ld=2'b11, din={8'hA5,8'h3C} -> top=0xA5 (source 1 wins), count increments by 1.
- **Fill, overflow, recovery**:
  - Push 0x01,0x02,0x03,0x04 -> full=1, top=0x04, next=0x03.
  - Further push of 0x05 -> stack unchanged, err=1.
  - pop -> top=0x03, count=3, err still 1.
  - clr_err -> err=0.
- **Swap/dup/pop semantics**:
  - Stack [top 0x07, 0x09]: swap -> top=0x09, next=0x07.
  - dup -> top=0x09, next=0x09, count=3.
  - pop ×3 -> empty=1, top=0, next=0.
  - Further pop -> err=1, count=0.
- **Simultaneous events**:
  - ld=2'b01 with pop in the same cycle -> push only, no err.
  - swap with count=1 plus clr_err while err=1 -> err stays 1.
- **Reset mid-operation**: at count=3 with err=1, assert rst together with ld=2'b01 -> count=0, top=0, err=0, no push.
